// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   state_t  : fetch FSM states (IDLE, REQ, HOLD)
//   RESET_PC : program counter value after reset
//   WORD_INC : byte increment between consecutive instruction words
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_INC = 32'd4;

  // Redirect targets are forced to a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit with a one-word prefetch buffer.
// The FSM requests the word at PC, parks it in the buffer (HOLD) and hands
// it to Instr when the controller raises IRWrite. PCWrite redirects the PC;
// a redirect while a read is in flight marks that read for discard and
// re-requests at the new PC once the memory answers.
//
// Ports
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   IRWrite   : load next instruction into Instr
//   PCWrite   : redirect, PC takes word-aligned Result
//   Result    : redirect target (bits [1:0] ignored)
//   mem_req   : instruction memory read request
//   mem_addr  : word-aligned read address
//   mem_ack   : read complete, mem_rdata valid this cycle
//   mem_rdata : read data
//   Instr     : instruction register
//   PC        : address of the next instruction to load into Instr
//   PCPlus4   : PC + 4
//   stall     : IRWrite cannot be honoured this cycle
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        IRWrite,
  input  logic        PCWrite,
  input  logic [31:0] Result,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        stall
);

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] instr, instr_nx;
  logic [31:0] req_addr, req_addr_nx;
  logic [31:0] buf_data, buf_data_nx;
  logic        discard, discard_nx;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  logic        unused_result_lo;

  assign target           = word_align(Result);
  assign pc_plus4         = pc + WORD_INC;
  assign unused_result_lo = ^Result[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr    <= 32'h0;
      req_addr <= RESET_PC;
      buf_data <= 32'h0;
      discard  <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      instr    <= instr_nx;
      req_addr <= req_addr_nx;
      buf_data <= buf_data_nx;
      discard  <= discard_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    instr_nx    = instr;
    req_addr_nx = req_addr;
    buf_data_nx = buf_data;
    discard_nx  = discard;

    if (PCWrite) pc_nx = target;

    case (state)
      IDLE: begin
        state_nx    = REQ;
        req_addr_nx = PCWrite ? target : pc;
      end

      REQ: begin
        if (discard) begin
          // Stale read in flight: once it returns, fetch the pending PC,
          // which may itself have just been redirected again.
          if (mem_ack) begin
            discard_nx  = 1'b0;
            req_addr_nx = PCWrite ? target : pc;
          end
        end else if (PCWrite) begin
          if (mem_ack) req_addr_nx = target;
          else         discard_nx  = 1'b1;
        end else if (mem_ack) begin
          buf_data_nx = mem_rdata;
          state_nx    = HOLD;
        end
      end

      HOLD: begin
        if (PCWrite) begin
          state_nx    = REQ;
          req_addr_nx = target;
        end else if (IRWrite) begin
          instr_nx    = buf_data;
          pc_nx       = pc_plus4;
          req_addr_nx = pc_plus4;
          state_nx    = REQ;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  // Gated with reset so stall is low while reset is held, independent of
  // the controller's IRWrite.
  assign stall    = reset & IRWrite & (state != HOLD) & ~PCWrite;
  assign mem_req  = (state == REQ);
  assign mem_addr = req_addr;
  assign Instr    = instr;
  assign PC       = pc;
  assign PCPlus4  = pc_plus4;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        IRWrite = 1'b0;
  logic        PCWrite = 1'b0;
  logic [31:0] Result = 32'h0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        stall;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Result(Result), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .Instr(Instr), .PC(PC),
    .PCPlus4(PCPlus4), .stall(stall)
  );

  // Memory contents used by the randomized run: a fixed hash of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    IRWrite = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", PC); end
    total++; if (Instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", Instr); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
    total++; if (PCPlus4 !== 32'h4) begin bad++; $display("FAIL reset_pcplus4 got=%h exp=4", PCPlus4); end
    IRWrite = 1'b0;
  endtask

  task automatic test_fetch();
    reset = 1'b1;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hE3A0_1005;
    #1;
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL fetch_req got=%0b exp=1", mem_req); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL fetch_addr0 got=%h exp=0", mem_addr); end
    tick();
    mem_ack = 1'b0; IRWrite = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL fetch_hold_req got=%0b exp=0", mem_req); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fetch_hold_stall got=%0b exp=0", stall); end
    tick();
    IRWrite = 1'b0;
    #1;
    total++; if (Instr !== 32'hE3A0_1005) begin bad++; $display("FAIL fetch_instr got=%h exp=e3a01005", Instr); end
    total++; if (PC !== 32'h4) begin bad++; $display("FAIL fetch_pc got=%h exp=4", PC); end
    total++; if (mem_addr !== 32'h4 || mem_req !== 1'b1) begin bad++; $display("FAIL fetch_next_addr got=%h/%0b exp=4/1", mem_addr, mem_req); end
  endtask

  task automatic test_stall();
    IRWrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_wait%0d got=%0b exp=1", i, stall); end
      tick();
      total++; if (Instr !== 32'hE3A0_1005 || PC !== 32'h4) begin bad++; $display("FAIL stall_hold%0d instr=%h pc=%h exp=e3a01005/4", i, Instr, PC); end
    end
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_ackcycle got=%0b exp=1", stall); end
    tick();
    mem_ack = 1'b0;
    total++; if (Instr !== 32'hE3A0_1005 || PC !== 32'h4) begin bad++; $display("FAIL stall_nobypass instr=%h pc=%h exp=e3a01005/4", Instr, PC); end
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL stall_release got=%0b exp=0", stall); end
    tick();
    IRWrite = 1'b0;
    total++; if (Instr !== 32'h1234_5678 || PC !== 32'h8) begin bad++; $display("FAIL stall_load instr=%h pc=%h exp=12345678/8", Instr, PC); end
    total++; if (mem_addr !== 32'h8) begin bad++; $display("FAIL stall_next_addr got=%h exp=8", mem_addr); end
  endtask

  task automatic test_redirect_mid();
    PCWrite = 1'b1; Result = 32'h0000_0203;
    tick();
    PCWrite = 1'b0;
    total++; if (PC !== 32'h200) begin bad++; $display("FAIL mid_pc got=%h exp=200", PC); end
    total++; if (mem_addr !== 32'h8 || mem_req !== 1'b1) begin bad++; $display("FAIL mid_hold_addr got=%h/%0b exp=8/1", mem_addr, mem_req); end
    tick();
    total++; if (mem_addr !== 32'h8) begin bad++; $display("FAIL mid_hold_addr2 got=%h exp=8", mem_addr); end
    PCWrite = 1'b1; Result = 32'h0000_0300;
    tick();
    PCWrite = 1'b0;
    total++; if (PC !== 32'h300 || mem_addr !== 32'h8) begin bad++; $display("FAIL mid_retarget pc=%h addr=%h exp=300/8", PC, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin bad++; $display("FAIL mid_rereq got=%h/%0b exp=300/1", mem_addr, mem_req); end
    mem_rdata = 32'h1111_1111;
    tick();
    mem_ack = 1'b0; IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    total++; if (Instr !== 32'h1111_1111 || PC !== 32'h304) begin bad++; $display("FAIL mid_discard instr=%h pc=%h exp=11111111/304", Instr, PC); end
    total++; if (mem_addr !== 32'h304) begin bad++; $display("FAIL mid_next_addr got=%h exp=304", mem_addr); end
  endtask

  task automatic test_redirect_hold();
    mem_ack = 1'b1; mem_rdata = 32'hDDDD_DDDD;
    tick();
    mem_ack = 1'b0; IRWrite = 1'b1; PCWrite = 1'b1; Result = 32'h0000_0100;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL hold_both_stall got=%0b exp=0", stall); end
    tick();
    IRWrite = 1'b0; PCWrite = 1'b0;
    total++; if (PC !== 32'h100 || Instr !== 32'h1111_1111) begin bad++; $display("FAIL hold_redirect pc=%h instr=%h exp=100/11111111", PC, Instr); end
    total++; if (mem_addr !== 32'h100 || mem_req !== 1'b1) begin bad++; $display("FAIL hold_rereq got=%h/%0b exp=100/1", mem_addr, mem_req); end
    mem_ack = 1'b1; mem_rdata = 32'hEEEE_EEEE;
    tick();
    mem_ack = 1'b0; IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    total++; if (Instr !== 32'hEEEE_EEEE || PC !== 32'h104) begin bad++; $display("FAIL hold_dropped instr=%h pc=%h exp=eeeeeeee/104", Instr, PC); end
  endtask

  task automatic test_wrap();
    PCWrite = 1'b1; Result = 32'hFFFF_FFFF; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    tick();
    PCWrite = 1'b0; mem_ack = 1'b0;
    total++; if (PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc pc=%h pcp4=%h exp=fffffffc/0", PC, PCPlus4); end
    total++; if (mem_addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_addr got=%h exp=fffffffc", mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h0F0F_0F0F;
    tick();
    mem_ack = 1'b0; IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    total++; if (PC !== 32'h0 || Instr !== 32'h0F0F_0F0F) begin bad++; $display("FAIL wrap_inc pc=%h instr=%h exp=0/0f0f0f0f", PC, Instr); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL wrap_next_addr got=%h exp=0", mem_addr); end
  endtask

  task automatic test_reset_mid();
    PCWrite = 1'b1; Result = 32'h0000_0040; mem_ack = 1'b1; mem_rdata = 32'h0;
    tick();
    PCWrite = 1'b0; mem_ack = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin bad++; $display("FAIL rmid_pre got=%h/%0b exp=40/1", mem_addr, mem_req); end
    #2;
    reset = 1'b0; IRWrite = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL rmid_drop req=%0b stall=%0b exp=0/0", mem_req, stall); end
    total++; if (PC !== 32'h0 || Instr !== 32'h0 || mem_addr !== 32'h0) begin bad++; $display("FAIL rmid_clear pc=%h instr=%h addr=%h exp=0", PC, Instr, mem_addr); end
    IRWrite = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    reset = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rmid_idle got=%0b exp=0", mem_req); end
    tick();
    mem_ack = 1'b0;
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h0 || PC !== 32'h0) begin bad++; $display("FAIL rmid_restart addr=%h req=%0b pc=%h exp=0/1/0", mem_addr, mem_req, PC); end
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0; IRWrite = 1'b1;
    tick();
    IRWrite = 1'b0;
    total++; if (Instr !== 32'hCAFE_F00D || PC !== 32'h4) begin bad++; $display("FAIL rmid_fetch instr=%h pc=%h exp=cafef00d/4", Instr, PC); end
  endtask

  // Reference: the PC follows redirects and accepted loads; an accepted load
  // yields the memory word at the old PC. A word is ready only if a read of
  // the current PC completed with no redirect since it was issued.
  task automatic test_random();
    logic [31:0] m_pc, m_instr, m_addr, tgt;
    logic        m_idle, m_busy, m_ready, m_stale;
    logic        irw, pcw, ack;
    int          nbad;
    nbad = bad;
    reset = 1'b0; IRWrite = 1'b0; PCWrite = 1'b0; mem_ack = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    m_pc = 32'h0; m_instr = 32'h0; m_addr = 32'h0;
    m_idle = 1'b1; m_busy = 1'b0; m_ready = 1'b0; m_stale = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      irw = ($urandom_range(0, 1) == 1);
      pcw = ($urandom_range(0, 7) == 0);
      ack = m_busy && ($urandom_range(0, 2) == 0);
      Result    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      IRWrite   = irw;
      PCWrite   = pcw;
      mem_ack   = ack;
      mem_rdata = ack ? memf(mem_addr) : $urandom;
      #1;
      total++; if (mem_req !== m_busy) begin bad++; $display("FAIL rnd_req c=%0d got=%0b exp=%0b", cyc, mem_req, m_busy); end
      total++; if (stall !== (irw & ~m_ready & ~pcw)) begin bad++; $display("FAIL rnd_stall c=%0d got=%0b exp=%0b", cyc, stall, irw & ~m_ready & ~pcw); end
      total++; if (PCPlus4 !== m_pc + 32'd4) begin bad++; $display("FAIL rnd_pcplus4 c=%0d got=%h exp=%h", cyc, PCPlus4, m_pc + 32'd4); end
      if (m_busy) begin
        total++; if (mem_addr !== m_addr) begin bad++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", cyc, mem_addr, m_addr); end
      end
      tgt = {Result[31:2], 2'b00};
      if (pcw) begin
        m_ready = 1'b0;
        if (m_busy && !ack) m_stale = 1'b1;
        else begin m_stale = 1'b0; m_busy = 1'b1; m_addr = tgt; end
        m_idle = 1'b0;
        m_pc = tgt;
      end else if (m_idle) begin
        m_idle = 1'b0; m_busy = 1'b1; m_addr = m_pc;
      end else if (m_busy) begin
        if (ack) begin
          if (m_stale) begin m_stale = 1'b0; m_addr = m_pc; end
          else begin m_busy = 1'b0; m_ready = 1'b1; end
        end
      end else if (m_ready && irw) begin
        m_instr = memf(m_pc);
        m_pc    = m_pc + 32'd4;
        m_ready = 1'b0; m_busy = 1'b1; m_addr = m_pc;
      end
      tick();
      total++; if (PC !== m_pc) begin bad++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", cyc, PC, m_pc); end
      total++; if (Instr !== m_instr) begin bad++; $display("FAIL rnd_instr c=%0d got=%h exp=%h", cyc, Instr, m_instr); end
      if (bad - nbad > 20) break;
    end
    IRWrite = 1'b0; PCWrite = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_mid();
    test_redirect_hold();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have the port IRWrite, input, 1 bit: controller request to load the next instruction into Instr.
REQ-004 The block SHALL have the port PCWrite, input, 1 bit: controller redirect; PC takes Result.
REQ-005 The block SHALL have the port Result, input, 32 bits: redirect target; bits [1:0] are ignored and treated as 0.
REQ-006 The block SHALL have the port mem_req, output, 1 bit: instruction-memory read request.
REQ-007 The block SHALL have the port mem_addr, output, 32 bits: word-aligned read address.
REQ-008 The block SHALL have the port mem_ack, input, 1 bit: read complete; mem_rdata is valid in the same cycle.
REQ-009 The block SHALL have the port mem_rdata, input, 32 bits: read data.
REQ-010 The block SHALL have the port Instr, output, 32 bits: instruction register driving the controller and datapath.
REQ-011 The block SHALL have the port PC, output, 32 bits: address of the next instruction to be loaded into Instr.
REQ-012 The block SHALL have the port PCPlus4, output, 32 bits: PC+4, combinational.
REQ-013 The block SHALL have the port stall, output, 1 bit: high when IRWrite=1 cannot be honoured this cycle.

Function
REQ-014 The FSM SHALL have three states: IDLE, REQ and HOLD; HOLD means the one-word prefetch buffer is valid.
REQ-015 IDLE SHALL go to REQ unconditionally on the next cycle.
REQ-016 In REQ, mem_req SHALL be 1 and mem_addr SHALL equal the latched request address; both SHALL stay stable until mem_ack.
REQ-017 REQ with mem_ack=1 and no pending discard SHALL capture mem_rdata into the buffer and go to HOLD.
REQ-018 In HOLD, mem_req SHALL be 0.
REQ-019 In HOLD, IRWrite=1 with PCWrite=0 SHALL, in one cycle: set Instr to the buffer, set PC to PC+4, and go to REQ with address PC+4.
REQ-020 stall SHALL equal IRWrite AND (state != HOLD) AND NOT PCWrite.
REQ-021 A stalled IRWrite SHALL leave Instr and PC unchanged; the buffer is not bypassed on the mem_ack cycle.
REQ-022 PCWrite=1 SHALL set PC to {Result[31:2],2'b00} and invalidate the buffer, overriding any simultaneous IRWrite.
REQ-023 After PCWrite in HOLD, or in REQ with mem_ack=1, the FSM SHALL go to REQ at the new PC and discard the returned data.
REQ-024 After PCWrite in REQ with mem_ack=0, the block SHALL set a discard flag, hold the old mem_addr until mem_ack, drop that data, then re-request at the new PC.
REQ-025 A further PCWrite while the discard flag is set SHALL update only the pending target address.
REQ-026 Address arithmetic SHALL be modulo 2^32: PC 0xFFFFFFFC increments to 0x00000000.
REQ-027 The minimum latency SHALL be: request issued in cycle n, mem_ack in n, buffer valid in n+1, Instr loaded at the end of n+1 when IRWrite=1.

Reset
REQ-028 While reset=0, the state SHALL be IDLE, PC, Instr and the request address SHALL be 0, and the buffer and discard flag SHALL be cleared.
REQ-029 While reset=0, mem_req and stall SHALL be 0.
REQ-030 Reset assertion during REQ SHALL drop the outstanding request without waiting for mem_ack; a late mem_ack in IDLE SHALL be ignored.

Structure
REQ-031 State encodings and the reset PC value (32'h0) SHALL live in the shared package.
REQ-032 The block SHALL contain no sub-module; the PC+4 adder and the one-entry buffer SHALL be inline.

Verification
REQ-033 Directed test, reset and fetch: release reset, memory acks in the same cycle with 0xE3A01005 -> mem_addr=0; after IRWrite, Instr=0xE3A01005, PC=4, mem_addr=4.
REQ-034 Directed test, stall: IRWrite=1 while memory acks 3 cycles late -> stall=1 for those cycles, Instr is unchanged, and it loads the cycle after the ack.
REQ-035 Directed test, redirect in HOLD: PCWrite=1 with Result=0x100 -> PC=0x100, the buffer is dropped, and the next mem_addr is 0x100.
REQ-036 Directed test, redirect mid-request: PCWrite while a fetch at address 8 is unacked -> mem_addr stays 8 until the ack, that data is discarded, then a request to the new target is issued.
REQ-037 Directed test, simultaneous events and wrap: IRWrite and PCWrite in the same cycle -> PCWrite wins; PC=0xFFFFFFFC plus IRWrite -> PC=0.
REQ-038 Directed test, reset mid-request: reset=0 while mem_req=1 -> mem_req drops immediately; after release, fetch restarts at 0.
